multiport_frame_memory: RTL and testbench

- Parametrised successor to the 2-write / 3-read data memory used by the pipelined CPU.
- Adds per-port byte enables, a defined write-collision rule, optional read-during-write forwarding, a hardware clear sequencer, and an auto-scanning frame read port.
- The frame read port runs on the CPU clock and streams a W x H picture region to the display path with framing flags.
- Sits between the CPU memory stage (load/store, fetch) and the picture output logic.

---
 rtl/multiport_frame_memory.sv | 188 ++++++++++++++++++
 tb/tb_multiport_frame_memory.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_frame_memory.sv
// Dual-write, multi-read word memory with byte enables, a power-on clear
// sequencer and an auto-scanning frame read port for the display path.
module multiport_frame_memory #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 11,
    parameter int NUM_RD      = 3,
    parameter int CLEAR_WORDS = 1792,
    parameter int RD_FWD      = 0,
    parameter int FRAME_BASE  = 1792,
    parameter int FRAME_W     = 16,
    parameter int FRAME_H     = 16,
    parameter int PIX_W       = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_en,
    input  logic [ADDR_W-1:0]        w_adrs,
    input  logic [DATA_W/8-1:0]      w_be,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     w_en2,
    input  logic [ADDR_W-1:0]        w_adrs2,
    input  logic [DATA_W/8-1:0]      w_be2,
    input  logic [DATA_W-1:0]        data_in2,
    output logic                     w_valid1,
    output logic                     w_valid2,
    input  logic [NUM_RD-1:0]        r_en,
    input  logic [NUM_RD*ADDR_W-1:0] r_adrs,
    output logic [NUM_RD-1:0]        r_valid,
    output logic [NUM_RD*DATA_W-1:0] data_out,
    input  logic                     scan_en,
    input  logic                     scan_restart,
    output logic [PIX_W-1:0]         scan_data,
    output logic                     scan_valid,
    output logic                     scan_sof,
    output logic                     scan_eol,
    output logic                     scan_eof,
    output logic                     busy
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int XW    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int YW    = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);
    localparam logic [XW-1:0]     X_LAST   = XW'(FRAME_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(FRAME_H - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                    r_state, w_state_nxt;
    logic [ADDR_W-1:0]         r_clr_ptr;
    logic [DATA_W-1:0]         r_mem [DEPTH];
    logic                      w_run, w_wr1, w_wr2;
    logic [DATA_W-1:0]         w_new1, w_old2, w_new2;
    logic [DATA_W-1:0]         w_rd_word [NUM_RD];
    logic                      r_wv1, r_wv2;
    logic [NUM_RD-1:0]         r_rv;
    logic [NUM_RD*DATA_W-1:0]  r_dout;
    logic [XW-1:0]             r_x;
    logic [YW-1:0]             r_y;
    logic [ADDR_W-1:0]         w_scan_adr;
    logic                      w_x_last, w_y_last;
    logic [PIX_W-1:0]          r_sdata;
    logic                      r_sv, r_sof, r_eol, r_eof;

    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] din,
        input logic [NB-1:0]     be
    );
        f_merge = old;
        for (int b = 0; b < NB; b++)
            if (be[b]) f_merge[b*8 +: 8] = din[b*8 +: 8];
    endfunction

    assign w_run = (r_state == S_RUN);
    assign busy  = (r_state == S_CLEAR);
    assign w_wr1 = w_run & w_en;
    assign w_wr2 = w_run & w_en2;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_clr_ptr == CLR_LAST)
            w_state_nxt = S_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_run) r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // Port 2 merges on top of port 1's result so shared lanes take port 2 data.
    assign w_new1 = f_merge(r_mem[w_adrs], data_in, w_be);
    assign w_old2 = (w_wr1 && w_adrs2 == w_adrs) ? w_new1 : r_mem[w_adrs2];
    assign w_new2 = f_merge(w_old2, data_in2, w_be2);

    always_ff @(posedge clk) begin
        if (!w_run) r_mem[r_clr_ptr] <= '0;
        if (w_wr1)  r_mem[w_adrs]    <= w_new1;
        if (w_wr2)  r_mem[w_adrs2]   <= w_new2;
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_word[k] = r_mem[r_adrs[k*ADDR_W +: ADDR_W]];
            if (RD_FWD != 0) begin
                if (w_wr2 && r_adrs[k*ADDR_W +: ADDR_W] == w_adrs2)
                    w_rd_word[k] = w_new2;
                else if (w_wr1 && r_adrs[k*ADDR_W +: ADDR_W] == w_adrs)
                    w_rd_word[k] = w_new1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wv1  <= 1'b0;
            r_wv2  <= 1'b0;
            r_rv   <= '0;
            r_dout <= '0;
        end else begin
            r_wv1 <= w_wr1;
            r_wv2 <= w_wr2;
            for (int k = 0; k < NUM_RD; k++) begin
                r_rv[k] <= w_run & r_en[k];
                if (w_run && r_en[k])
                    r_dout[k*DATA_W +: DATA_W] <= w_rd_word[k];
            end
        end
    end

    assign w_scan_adr = ADDR_W'(FRAME_BASE) + ADDR_W'(r_y) * ADDR_W'(FRAME_W)
                      + ADDR_W'(r_x);
    assign w_x_last   = (r_x == X_LAST);
    assign w_y_last   = (r_y == Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_sdata <= '0;
            r_sv    <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (w_run) begin
            if (scan_restart) begin
                r_x   <= '0;
                r_y   <= '0;
                r_sv  <= 1'b0;
                r_sof <= 1'b0;
                r_eol <= 1'b0;
                r_eof <= 1'b0;
            end else if (scan_en) begin
                r_sv    <= 1'b1;
                r_sdata <= PIX_W'(r_mem[w_scan_adr]);
                r_sof   <= (r_x == '0) && (r_y == '0);
                r_eol   <= w_x_last;
                r_eof   <= w_x_last && w_y_last;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end else begin
                r_sv  <= 1'b0;
                r_sof <= 1'b0;
                r_eol <= 1'b0;
                r_eof <= 1'b0;
            end
        end
    end

    assign w_valid1   = r_wv1;
    assign w_valid2   = r_wv2;
    assign r_valid    = r_rv;
    assign data_out   = r_dout;
    assign scan_data  = r_sdata;
    assign scan_valid = r_sv;
    assign scan_sof   = r_sof;
    assign scan_eol   = r_eol;
    assign scan_eof   = r_eof;
endmodule

// File: tb/tb_multiport_frame_memory.sv
// Directed bench for multiport_frame_memory: clear sequencer, collisions,
// read-old vs forwarding, multi-read, frame scan and mid-operation reset.
module tb_multiport_frame_memory;
    logic        clk, reset;
    logic        w_en, w_en2;
    logic [10:0] w_adrs, w_adrs2;
    logic [3:0]  w_be, w_be2;
    logic [31:0] data_in, data_in2;
    logic [2:0]  r_en;
    logic [32:0] r_adrs;
    logic        scan_en, scan_restart;

    logic        wv1, wv2, sv, sof, eol, eof, bsy;
    logic [2:0]  rv;
    logic [95:0] dout;
    logic [23:0] sdata;
    logic        f_wv1, f_wv2, f_sv, f_sof, f_eol, f_eof, f_bsy;
    logic [2:0]  f_rv;
    logic [95:0] f_dout;
    logic [23:0] f_sdata;

    int n_pass = 0;
    int n_total = 0;

    multiport_frame_memory dut (
        .clk(clk), .reset(reset),
        .w_en(w_en), .w_adrs(w_adrs), .w_be(w_be), .data_in(data_in),
        .w_en2(w_en2), .w_adrs2(w_adrs2), .w_be2(w_be2), .data_in2(data_in2),
        .w_valid1(wv1), .w_valid2(wv2),
        .r_en(r_en), .r_adrs(r_adrs), .r_valid(rv), .data_out(dout),
        .scan_en(scan_en), .scan_restart(scan_restart),
        .scan_data(sdata), .scan_valid(sv), .scan_sof(sof),
        .scan_eol(eol), .scan_eof(eof), .busy(bsy)
    );

    multiport_frame_memory #(.RD_FWD(1)) dut_fwd (
        .clk(clk), .reset(reset),
        .w_en(w_en), .w_adrs(w_adrs), .w_be(w_be), .data_in(data_in),
        .w_en2(w_en2), .w_adrs2(w_adrs2), .w_be2(w_be2), .data_in2(data_in2),
        .w_valid1(f_wv1), .w_valid2(f_wv2),
        .r_en(r_en), .r_adrs(r_adrs), .r_valid(f_rv), .data_out(f_dout),
        .scan_en(scan_en), .scan_restart(scan_restart),
        .scan_data(f_sdata), .scan_valid(f_sv), .scan_sof(f_sof),
        .scan_eol(f_eol), .scan_eof(f_eof), .busy(f_bsy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we, we2;
        logic [10:0] wa, wa2;
        logic [3:0]  be, be2;
        logic [31:0] d, d2;
        logic [2:0]  ren;
        logic [10:0] ra0, ra1, ra2;
        logic        ewv1, ewv2;
        logic [2:0]  erv;
        logic [95:0] edo, efw;
    } vec_t;

    vec_t tv [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic chk_pix(input string nm, input int p);
        logic [27:0] e;
        e = {1'b1, p == 0, (p % 16) == 15, p == 255, 24'(p)};
        chk(nm, 128'({sv, sof, eol, eof, sdata}), 128'(e));
    endtask

    task automatic clear_wait(output int n);
        n = 0;
        while (bsy && n < 3000) begin
            tick();
            n++;
        end
    endtask

    localparam logic [95:0] D0  = {32'hFFFFFFFF, 32'h0, 32'h0};
    localparam logic [95:0] D1  = {32'hFFFFFFFF, 32'h0, 32'h11112222};
    localparam logic [95:0] D3A = {32'hFFFFFFFF, 32'h0, 32'h0000000A};
    localparam logic [95:0] D3F = {32'hFFFFFFFF, 32'h0, 32'h0000000B};
    localparam logic [95:0] D4  = {32'hFFFFFFFF, 32'h11112222, 32'h0000000B};
    localparam logic [95:0] D5  = {32'h77000077, 32'h11112222, 32'h33333333};
    localparam logic [95:0] D9A = {32'h00000000, 32'h11112222, 32'h33333333};
    localparam logic [95:0] D9F = {32'hAABBBB00, 32'h11112222, 32'h33333333};

    initial begin
        int n;
        tv[0]  = '{1'b1, 1'b1, 11'h010, 11'h010, 4'hF, 4'h3, 32'h11111111,
                   32'h22222222, 3'b000, 11'h0, 11'h0, 11'h0,
                   1'b1, 1'b1, 3'b000, D0, D0};
        tv[1]  = '{1'b0, 1'b0, 11'h0, 11'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   3'b001, 11'h010, 11'h0, 11'h0,
                   1'b0, 1'b0, 3'b001, D1, D1};
        tv[2]  = '{1'b1, 1'b1, 11'h005, 11'h003, 4'hF, 4'hF, 32'h0000000A,
                   32'h33333333, 3'b000, 11'h0, 11'h0, 11'h0,
                   1'b1, 1'b1, 3'b000, D1, D1};
        tv[3]  = '{1'b1, 1'b1, 11'h005, 11'h007, 4'hF, 4'h9, 32'h0000000B,
                   32'h77AAAA77, 3'b001, 11'h005, 11'h0, 11'h0,
                   1'b1, 1'b1, 3'b001, D3A, D3F};
        tv[4]  = '{1'b0, 1'b0, 11'h0, 11'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   3'b011, 11'h005, 11'h010, 11'h0,
                   1'b0, 1'b0, 3'b011, D4, D4};
        tv[5]  = '{1'b0, 1'b0, 11'h0, 11'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   3'b101, 11'h003, 11'h010, 11'h007,
                   1'b0, 1'b0, 3'b101, D5, D5};
        tv[6]  = '{1'b0, 1'b0, 11'h0, 11'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   3'b000, 11'h003, 11'h010, 11'h007,
                   1'b0, 1'b0, 3'b000, D5, D5};
        tv[7]  = '{1'b1, 1'b0, 11'h003, 11'h0, 4'h0, 4'h0, 32'hFFFFFFFF, 32'h0,
                   3'b000, 11'h0, 11'h0, 11'h0,
                   1'b1, 1'b0, 3'b000, D5, D5};
        tv[8]  = '{1'b0, 1'b0, 11'h0, 11'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   3'b001, 11'h003, 11'h0, 11'h0,
                   1'b0, 1'b0, 3'b001, D5, D5};
        tv[9]  = '{1'b1, 1'b1, 11'h009, 11'h009, 4'hC, 4'h6, 32'hAAAAAAAA,
                   32'hBBBBBBBB, 3'b100, 11'h0, 11'h0, 11'h009,
                   1'b1, 1'b1, 3'b100, D9A, D9F};
        tv[10] = '{1'b0, 1'b0, 11'h0, 11'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                   3'b100, 11'h0, 11'h0, 11'h009,
                   1'b0, 1'b0, 3'b100, D9F, D9F};

        reset = 1'b1;
        w_en = 0; w_en2 = 0; w_adrs = '0; w_adrs2 = '0;
        w_be = '0; w_be2 = '0; data_in = '0; data_in2 = '0;
        r_en = '0; r_adrs = '0; scan_en = 0; scan_restart = 0;
        tick();
        tick();
        chk("reset_flags", 128'({bsy, wv1, wv2, rv, sv, sof, eol, eof}),
            128'(10'b10_0000_0000));
        chk("reset_dout", 128'(dout), 128'(0));
        chk("reset_sdata", 128'(sdata), 128'(0));

        reset = 1'b0;
        clear_wait(n);
        chk("clear_len_1", 128'(n), 128'(1792));
        chk("fwd_busy", 128'(f_bsy), 128'(0));

        w_en = 1; w_adrs = 11'd0; w_be = 4'hF; data_in = 32'hFFFFFFFF;
        w_en2 = 1; w_adrs2 = 11'd1791; w_be2 = 4'hF; data_in2 = 32'hFFFFFFFF;
        tick();
        w_adrs = 11'd1792; w_en2 = 0;
        tick();
        w_en = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_wait(n);
        chk("clear_len_2", 128'(n), 128'(1792));
        r_en = 3'b111;
        r_adrs = {11'd1792, 11'd1791, 11'd0};
        tick();
        chk("clear_rv", 128'(rv), 128'(3'b111));
        chk("clear_data", 128'(dout), 128'(D0));
        r_en = '0;

        for (int i = 0; i < 11; i++) begin
            w_en = tv[i].we; w_adrs = tv[i].wa; w_be = tv[i].be;
            data_in = tv[i].d;
            w_en2 = tv[i].we2; w_adrs2 = tv[i].wa2; w_be2 = tv[i].be2;
            data_in2 = tv[i].d2;
            r_en = tv[i].ren;
            r_adrs = {tv[i].ra2, tv[i].ra1, tv[i].ra0};
            tick();
            chk($sformatf("v%0d_wv1", i), 128'(wv1), 128'(tv[i].ewv1));
            chk($sformatf("v%0d_wv2", i), 128'(wv2), 128'(tv[i].ewv2));
            chk($sformatf("v%0d_rv", i), 128'(rv), 128'(tv[i].erv));
            chk($sformatf("v%0d_dout", i), 128'(dout), 128'(tv[i].edo));
            chk($sformatf("v%0d_fwd", i), 128'(f_dout), 128'(tv[i].efw));
        end
        w_en = 0; w_en2 = 0; r_en = '0;

        w_be = 4'hF; w_be2 = 4'hF;
        for (int i = 0; i < 256; i += 2) begin
            w_en = 1; w_adrs = 11'(1792 + i); data_in = {8'hA5, 24'(i)};
            w_en2 = 1; w_adrs2 = 11'(1793 + i); data_in2 = {8'hA5, 24'(i + 1)};
            tick();
        end
        w_en = 0; w_en2 = 0;

        scan_en = 1;
        for (int c = 0; c < 300; c++) begin
            tick();
            chk_pix("scan", c % 256);
        end

        scan_restart = 1;
        tick();
        chk("restart_valid", 128'(sv), 128'(0));
        scan_restart = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk_pix("scan2", c);
        end
        scan_restart = 1;
        tick();
        chk("restart40_valid", 128'(sv), 128'(0));
        scan_restart = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_pix("after_restart", c);
        end
        scan_en = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("pause_valid", 128'(sv), 128'(0));
        end
        scan_en = 1;
        tick();
        chk_pix("resume", 3);

        w_en = 1; w_adrs = 11'(1792 + 4); data_in = 32'hFFFFFFFF;
        tick();
        chk_pix("scan_no_fwd", 4);
        w_en = 0;
        tick();
        chk_pix("scan_next", 5);

        reset = 1'b1;
        #1;
        chk("midreset_scan", 128'({bsy, sv, sof, eol, eof, sdata}),
            128'({1'b1, 4'b0, 24'h0}));
        chk("midreset_rw", 128'({wv1, wv2, rv, dout}), 128'(0));
        tick();
        reset = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        chk("midclear_busy", 128'(bsy), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_wait(n);
        chk("clear_len_3", 128'(n), 128'(1792));
        tick();
        chk_pix("scan_after_reset", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
